// File: rtl/ht_head_lookup.sv
// Hash-table head lookup stage: hashes the command key, reads the bucket head pointer, and owns the head RAM.
// Optional build macro HT_HASH_XOR_FOLD_EN selects an XOR-fold hash instead of the low key bits.
module ht_head_lookup #(
   parameter int KEY_WIDTH      = 18,
   parameter int VALUE_WIDTH    = 5,
   parameter int BUCKET_WIDTH   = 6,
   parameter int HEAD_PTR_WIDTH = 9
) (
   input  logic                                                            clk_i,
   input  logic                                                            rst_i,
   input  logic [KEY_WIDTH+VALUE_WIDTH+1:0]                                cmd_i,
   input  logic                                                            cmd_valid_i,
   output logic                                                            cmd_ready_o,
   output logic [KEY_WIDTH+VALUE_WIDTH+BUCKET_WIDTH+HEAD_PTR_WIDTH+2:0]    pdata_o,
   output logic                                                            pdata_valid_o,
   input  logic                                                            pdata_ready_i,
   input  logic                                                            head_wr_en_i,
   input  logic [BUCKET_WIDTH-1:0]                                         head_wr_bucket_i,
   input  logic [HEAD_PTR_WIDTH-1:0]                                       head_wr_ptr_i,
   input  logic                                                            head_wr_ptr_val_i,
   output logic                                                            init_done_o
);
   localparam int DEPTH = 1 << BUCKET_WIDTH;
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   typedef struct packed {
      logic [KEY_WIDTH-1:0]   key;
      logic [VALUE_WIDTH-1:0] value;
      logic [1:0]             opcode;
   } ht_command_t;

   typedef struct packed {
      logic [HEAD_PTR_WIDTH-1:0] ptr;
      logic                      val;
   } head_t;

   typedef struct packed {
      ht_command_t             cmd;
      logic [BUCKET_WIDTH-1:0] bucket;
      head_t                   head;
   } ht_pdata_t;

   logic [0:0]              state;
   logic [BUCKET_WIDTH-1:0] init_cnt;
   head_t                   mem [DEPTH];

   ht_command_t             cmd;
   logic [BUCKET_WIDTH-1:0] bucket;
   logic                    en, accept;
   logic                    wr_en;
   logic [BUCKET_WIDTH-1:0] wr_bucket;
   head_t                   wr_data, rd_head, s1_fwd;

   logic [2:1]              vld_pipe;
   ht_command_t             s1_cmd;
   logic [BUCKET_WIDTH-1:0] s1_bucket;
   head_t                   s1_head;
   ht_pdata_t               s2;
   logic                    s1_hit, s2_hit;

   assign cmd = cmd_i;

`ifdef HT_HASH_XOR_FOLD_EN
   localparam int NCH = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;
   logic [NCH*BUCKET_WIDTH-1:0] key_pad;

   // Top chunk is zero-extended when the key does not divide evenly.
   always_comb begin
      key_pad = '0;
      key_pad[KEY_WIDTH-1:0] = cmd.key;
      bucket = '0;
      for (int i = 0; i < NCH; i++)
         bucket = bucket ^ key_pad[i*BUCKET_WIDTH +: BUCKET_WIDTH];
   end
`else
   assign bucket = cmd.key[BUCKET_WIDTH-1:0];
`endif

   assign init_done_o   = (state == ST_RUN);
   assign pdata_valid_o = vld_pipe[2];
   assign pdata_o       = s2;
   assign en            = ~vld_pipe[2] | pdata_ready_i;
   assign cmd_ready_o   = init_done_o & en;
   assign accept        = cmd_valid_i & cmd_ready_o;

   // During INIT the clear sweep owns the write port and external writes are dropped.
   always_comb begin
      wr_en     = 1'b1;
      wr_bucket = init_cnt;
      wr_data   = '0;
      if (state == ST_RUN) begin
         wr_en     = head_wr_en_i;
         wr_bucket = head_wr_bucket_i;
         wr_data   = '{ptr: head_wr_ptr_i, val: head_wr_ptr_val_i};
      end
   end

   assign rd_head = (wr_en && wr_bucket == bucket) ? wr_data : mem[bucket];
   assign s1_hit  = wr_en && (wr_bucket == s1_bucket);
   assign s2_hit  = wr_en && (wr_bucket == s2.bucket);
   assign s1_fwd  = s1_hit ? wr_data : s1_head;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else if (state == ST_INIT) begin
         init_cnt <= init_cnt + 1'b1;
         if (&init_cnt) state <= ST_RUN;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_bucket] <= wr_data;
   end

   // Beats snoop the write port so stalled heads never go stale.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe  <= '0;
         s1_cmd    <= '0;
         s1_bucket <= '0;
         s1_head   <= '0;
         s2        <= '0;
      end else if (en) begin
         vld_pipe  <= {vld_pipe[1], accept};
         s1_cmd    <= cmd;
         s1_bucket <= bucket;
         s1_head   <= rd_head;
         s2        <= '{cmd: s1_cmd, bucket: s1_bucket, head: s1_fwd};
      end else begin
         if (s1_hit) s1_head <= wr_data;
         if (s2_hit) s2.head <= wr_data;
      end
   end
endmodule

// File: tb/tb_ht_head_lookup.sv
// Self-checking bench for ht_head_lookup: directed cases plus randomized traffic against a queue/table model.
module tb_ht_head_lookup;
   logic        clk = 1'b0;
   logic        rst_i;
   logic [24:0] cmd_i;
   logic        cmd_valid_i, cmd_ready_o;
   logic [40:0] pdata_o;
   logic        pdata_valid_o, pdata_ready_i;
   logic        head_wr_en_i;
   logic [5:0]  head_wr_bucket_i;
   logic [8:0]  head_wr_ptr_i;
   logic        head_wr_ptr_val_i;
   logic        init_done_o;

`ifdef HT_HASH_XOR_FOLD_EN
   localparam logic [5:0] B41 = 6'h00;
`else
   localparam logic [5:0] B41 = 6'h01;
`endif

   ht_head_lookup dut (
      .clk_i(clk), .rst_i(rst_i), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o), .pdata_o(pdata_o), .pdata_valid_o(pdata_valid_o),
      .pdata_ready_i(pdata_ready_i), .head_wr_en_i(head_wr_en_i),
      .head_wr_bucket_i(head_wr_bucket_i), .head_wr_ptr_i(head_wr_ptr_i),
      .head_wr_ptr_val_i(head_wr_ptr_val_i), .init_done_o(init_done_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference hash: plain arithmetic over 6-bit digits of the key.
   function automatic logic [5:0] mhash(input logic [17:0] k);
`ifdef HT_HASH_XOR_FOLD_EN
      int v = int'(k);
      logic [5:0] h = '0;
      while (v != 0) begin
         h = h ^ 6'(v % 64);
         v = v / 64;
      end
      return h;
`else
      return 6'(k % 64);
`endif
   endfunction

   // Model: head table, FIFO of accepted commands, and an init timer.
   logic [9:0]  m_tbl [64];
   logic [24:0] m_q [$];
   int          m_timer;
   bit          m_run, after_rst, prev_stall;
   logic [40:0] prev_pd;
   logic [24:0] c;
   logic [5:0]  b;
   int          n_acc = 0;

   always @(negedge clk) begin
      if (rst_i) begin
         m_q.delete();
         m_timer    = 0;
         m_run      = 0;
         after_rst  = 1;
         prev_stall = 0;
         for (int i = 0; i < 64; i++) m_tbl[i] = '0;
      end else begin
         if (after_rst) begin
            chk("rst_pdata_valid", 64'(pdata_valid_o), 0);
            chk("rst_cmd_ready", 64'(cmd_ready_o), 0);
            chk("rst_pdata", 64'(pdata_o), 0);
            after_rst = 0;
         end
         chk("init_done", 64'(init_done_o), 64'(m_run));
         chk("cmd_ready", 64'(cmd_ready_o), 64'(m_run && (!pdata_valid_o || pdata_ready_i)));
         chk("no_stale_valid", 64'(pdata_valid_o && m_q.size() == 0), 0);
         if (prev_stall) begin
            chk("hold_valid", 64'(pdata_valid_o), 1);
            chk("hold_cmd_bucket", 64'(pdata_o[40:10]), 64'(prev_pd[40:10]));
         end
         if (pdata_valid_o && pdata_ready_i && m_q.size() > 0) begin
            c = m_q.pop_front();
            b = mhash(c[24:7]);
            chk("beat", 64'(pdata_o), 64'({c, b, m_tbl[b]}));
         end
         prev_stall = pdata_valid_o && !pdata_ready_i;
         prev_pd    = pdata_o;
         if (cmd_valid_i && cmd_ready_o) begin
            m_q.push_back(cmd_i);
            n_acc++;
         end
         if (m_run && head_wr_en_i) m_tbl[head_wr_bucket_i] = {head_wr_ptr_i, head_wr_ptr_val_i};
         if (!m_run) begin
            m_timer++;
            if (m_timer == 64) m_run = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid_i = 0; head_wr_en_i = 0; pdata_ready_i = 1;
   endtask

   task automatic wait_init(input string nm, input bit rand_wr);
      int n = 0;
      while (!init_done_o && n < 200) begin
         if (rand_wr) begin
            head_wr_en_i = 1;
            head_wr_bucket_i = 6'($urandom_range(0, 63));
            head_wr_ptr_i = 9'($urandom);
            head_wr_ptr_val_i = 1;
         end
         step();
         n++;
      end
      head_wr_en_i = 0;
      chk(nm, 64'(n), 64);
   endtask

   task automatic pulse_reset();
      rst_i = 1;
      step();
      rst_i = 0;
   endtask

   // Accept at cycle N with an empty pipe and ready high; expect the beat at N+2.
   task automatic directed(input string nm, input logic [17:0] key, input bit wr_same,
                           input logic [8:0] wptr, input logic [8:0] eptr, input logic eval);
      logic [24:0] cv;
      cv = {key, 5'h13, 2'b01};
      cmd_i = cv; cmd_valid_i = 1;
      if (wr_same) begin
         head_wr_en_i = 1; head_wr_bucket_i = B41; head_wr_ptr_i = wptr; head_wr_ptr_val_i = 1;
      end
      @(negedge clk);
      chk({nm, "_accept"}, 64'(cmd_ready_o), 1);
      step();
      cmd_valid_i = 0; head_wr_en_i = 0;
      @(negedge clk);
      chk({nm, "_n1_valid"}, 64'(pdata_valid_o), 0);
      step();
      @(negedge clk);
      chk({nm, "_n2_valid"}, 64'(pdata_valid_o), 1);
      chk({nm, "_cmd"}, 64'(pdata_o[40:16]), 64'(cv));
      chk({nm, "_bucket"}, 64'(pdata_o[15:10]), 64'(B41));
      chk({nm, "_ptr"}, 64'(pdata_o[9:1]), 64'(eptr));
      chk({nm, "_ptr_val"}, 64'(pdata_o[0]), 64'(eval));
      step();
   endtask

   task automatic random_traffic(input int ncmd);
      int target = n_acc + ncmd;
      int cyc = 0;
      while (n_acc < target && cyc < 5000) begin
         step();
         cmd_valid_i = ($urandom_range(0, 3) != 0);
         cmd_i = {18'($urandom) & 18'h3F007, 5'($urandom), 2'($urandom)};
         pdata_ready_i = ($urandom_range(0, 2) != 0);
         head_wr_en_i = ($urandom_range(0, 2) == 0);
         head_wr_bucket_i = 6'($urandom_range(0, 7));
         head_wr_ptr_i = 9'($urandom);
         head_wr_ptr_val_i = 1'($urandom);
         cyc++;
      end
      chk("random_within_budget", 64'(n_acc >= target), 1);
   endtask

   task automatic drain(input string nm);
      step();
      idle_inputs();
      repeat (6) step();
      @(negedge clk);
      chk(nm, 64'(m_q.size()), 0);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1; cmd_i = '0; idle_inputs();
      head_wr_bucket_i = '0; head_wr_ptr_i = '0; head_wr_ptr_val_i = 0;
      chk("hash_pin_0x41", 64'(mhash(18'h00041)), 64'(B41));
      repeat (3) step();
      rst_i = 0;
      // Writes during the clear must be ignored; first lookup returns an empty head.
      wait_init("init_latency", 1);
      directed("search_empty", 18'h00041, 0, 9'h0, 9'h000, 0);

      head_wr_en_i = 1; head_wr_bucket_i = B41; head_wr_ptr_i = 9'h1A5; head_wr_ptr_val_i = 1;
      step();
      head_wr_en_i = 0;
      directed("after_write", 18'h00041, 0, 9'h0, 9'h1A5, 1);
      directed("same_cycle_write", 18'h00041, 1, 9'h0C7, 9'h0C7, 1);

      // Stall holding a beat for bucket B41, update it mid-stall, then release.
      pdata_ready_i = 0;
      cmd_valid_i = 1; cmd_i = {18'h00041, 5'h07, 2'b10};
      step();
      cmd_i = {18'h00042, 5'h08, 2'b11};
      step();
      cmd_valid_i = 0;
      repeat (2) step();
      head_wr_en_i = 1; head_wr_bucket_i = B41; head_wr_ptr_i = 9'h033; head_wr_ptr_val_i = 1;
      step();
      head_wr_en_i = 0;
      repeat (2) step();
      pdata_ready_i = 1;
      @(negedge clk);
      chk("stall_release_valid", 64'(pdata_valid_o), 1);
      chk("stall_release_ptr", 64'(pdata_o[9:0]), 64'({9'h033, 1'b1}));
      chk("stall_release_key", 64'(pdata_o[40:23]), 64'h41);
      step();
      @(negedge clk);
      chk("stall_next_valid", 64'(pdata_valid_o), 1);
      chk("stall_next_key", 64'(pdata_o[40:23]), 64'h42);
      step();

      random_traffic(200);
      drain("drain_random");

      // Reset mid-INIT at counter 20: the clear must restart in full.
      pulse_reset();
      repeat (20) step();
      pulse_reset();
      wait_init("init_restart_latency", 0);

      // Reset with beats in flight.
      random_traffic(30);
      pdata_ready_i = 0; cmd_valid_i = 1; head_wr_en_i = 0;
      repeat (3) step();
      pulse_reset();
      cmd_valid_i = 0; pdata_ready_i = 1;
      wait_init("init_after_stream_reset", 0);
      random_traffic(60);
      drain("drain_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
